// File: rtl/edge_trig.sv
// Edge trigger: synchronizes an asynchronous input, optionally filters it for a
// minimum persistence, and emits registered rise/fall/any pulses on accepted changes.
module edge_trig #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 0,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic any
);

   localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   any_q, any_d;
   logic                   s_last;

   assign s_last = sync_q[SYNC_STAGES-1];

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      sync_d  = sync_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      sync_d[0] = in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      if (s_last != level_q) begin
         if (cnt_q == CNT_MAX) begin
            // The change has persisted long enough: accept it and pulse in the same edge.
            level_d = s_last;
            rise_d  = s_last;
            fall_d  = ~s_last;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      any_d = rise_d | fall_d;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values; the synchronizer chain is reset too so no stale level leaks out.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
         cnt_q   <= '0;
         level_q <= INIT_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         any_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         any_q   <= any_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign any   = any_q;

endmodule

// File: tb/tb_edge_trig.sv
// Scoreboard bench for edge_trig: three configurations (default, 3-cycle filter,
// INIT_LEVEL=1) driven with directed vectors; a monitor matches every pulse to the queue.
module tb_edge_trig;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_ab, rst_c;
   logic in_a, in_b, in_c;
   logic level_a, rise_a, fall_a, any_a;
   logic level_b, rise_b, fall_b, any_b;
   logic level_c, rise_c, fall_c, any_c;

   edge_trig dut_a (
      .clk(clk), .rst(rst_ab), .in(in_a),
      .level(level_a), .rise(rise_a), .fall(fall_a), .any(any_a)
   );

   edge_trig #(.FILTER_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst_ab), .in(in_b),
      .level(level_b), .rise(rise_b), .fall(fall_b), .any(any_b)
   );

   edge_trig #(.INIT_LEVEL(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .in(in_c),
      .level(level_c), .rise(rise_c), .fall(fall_c), .any(any_c)
   );

   typedef struct {
      logic r;
      logic f;
      int   due;
   } exp_t;

   exp_t q[3][$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int d, input logic r, input logic f, input int due);
      exp_t e;
      e.r = r;
      e.f = f;
      e.due = due;
      q[d].push_back(e);
   endtask

   task automatic mon(input int d, input logic r, input logic f, input logic a);
      exp_t e;
      while (q[d].size() > 0 && q[d][0].due < cyc) begin
         e = q[d].pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL dut%0d_missed: no pulse seen, expected rise=%0b fall=%0b at cycle %0d",
                  d, e.r, e.f, e.due);
      end
      if (r || f || a) begin
         if (q[d].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_unexpected: got rise=%0b fall=%0b any=%0b at cycle %0d, expected no pulse",
                     d, r, f, a, cyc);
         end else begin
            e = q[d].pop_front();
            check($sformatf("dut%0d_cycle", d), cyc, e.due);
            check($sformatf("dut%0d_rise", d), int'(r), int'(e.r));
            check($sformatf("dut%0d_fall", d), int'(f), int'(e.f));
            check($sformatf("dut%0d_any", d), int'(a), int'(e.r | e.f));
            check($sformatf("dut%0d_excl", d), int'(r & f), 0);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, rise_a, fall_a, any_a);
      mon(1, rise_b, fall_b, any_b);
      mon(2, rise_c, fall_c, any_c);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ab = 1'b1;
      rst_c  = 1'b1;
      in_a   = 1'b1;
      in_b   = 1'b0;
      in_c   = 1'b1;
      step(3);
      check("a_rst_level", int'(level_a), 0);
      check("a_rst_rise", int'(rise_a), 0);
      check("a_rst_fall", int'(fall_a), 0);
      check("a_rst_any", int'(any_a), 0);
      check("b_rst_level", int'(level_b), 0);
      check("b_rst_any", int'(any_b), 0);
      check("c_rst_level", int'(level_c), 1);
      check("c_rst_any", int'(any_c), 0);

      // Release with in_a already high: a normal rise is expected three edges later.
      rst_ab = 1'b0;
      rst_c  = 1'b0;
      push(0, 1'b1, 1'b0, cyc + 3);
      step(6);
      check("a_level_after_release", int'(level_a), 1);

      in_a = 1'b0;
      push(0, 1'b0, 1'b1, cyc + 3);
      step(6);
      check("a_level_after_fall", int'(level_a), 0);

      in_a = 1'b1;
      push(0, 1'b1, 1'b0, cyc + 3);
      step(6);
      check("a_level_after_rise", int'(level_a), 1);
      in_a = 1'b0;
      push(0, 1'b0, 1'b1, cyc + 3);
      step(6);

      // Filtered instance: two 3-cycle glitches split by one low cycle must be rejected.
      in_b = 1'b1;
      step(3);
      in_b = 1'b0;
      step(1);
      in_b = 1'b1;
      step(3);
      in_b = 1'b0;
      step(8);
      check("b_level_after_glitch", int'(level_b), 0);

      in_b = 1'b1;
      push(1, 1'b1, 1'b0, cyc + 6);
      step(4);
      in_b = 1'b0;
      push(1, 1'b0, 1'b1, cyc + 6);
      step(10);
      check("b_level_final", int'(level_b), 0);

      for (int i = 0; i < 10; i++) begin
         in_a = ~i[0];
         push(0, in_a, ~in_a, cyc + 3);
         step(1);
      end
      step(15);
      check("a_level_after_toggle", int'(level_a), 0);

      // Reset lands exactly on the edge where a fall pulse would fire.
      in_c = 1'b0;
      step(1);
      in_c = 1'b1;
      step(1);
      rst_c = 1'b1;
      step(1);
      rst_c = 1'b0;
      check("c_fall_suppressed", int'(fall_c), 0);
      check("c_any_suppressed", int'(any_c), 0);
      check("c_level_reloaded", int'(level_c), 1);
      step(10);
      check("c_level_held", int'(level_c), 1);

      step(5);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("dut%0d_drained", d), q[d].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
